// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and limits for the multi-channel PWM block.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [0:0] {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int MAX_CH = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_multichannel_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multichannel_if
//  Description : Config inputs from the register file and PWM status/outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multichannel_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 16
) ();

    logic                    enable;
    logic                    cfg_load;
    logic                    center_mode;
    logic [CNT_W-1:0]        period;
    logic [PSC_W-1:0]        prescaler;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [NUM_CH-1:0]       polarity;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_tick;
    logic                    cfg_pending;

    modport master (
        output enable, cfg_load, center_mode, period, prescaler, duty, polarity,
        input  pwm_out, period_tick, cfg_pending
    );

    modport slave (
        input  enable, cfg_load, center_mode, period, prescaler, duty, polarity,
        output pwm_out, period_tick, cfg_pending
    );

endinterface
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timebase
//  Description : Prescaler, edge/center counter with direction FSM and
//                period-boundary detection (o_boundary is the pre-edge strobe).
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  pwm_mode_e        i_mode,
    input  logic [CNT_W-1:0] i_period,
    input  logic [PSC_W-1:0] i_prescaler,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_boundary
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PSC_W-1:0] c_psc_one = PSC_W'(1);

    logic [PSC_W-1:0] r_psc;
    logic [CNT_W-1:0] r_cnt;
    pwm_dir_e         r_dir;

    logic [PSC_W-1:0] w_psc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    pwm_dir_e         w_dir_nxt;
    logic             w_tick;
    logic             w_center;
    logic             w_boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_psc <= w_psc_nxt;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    always_comb begin
        w_tick     = i_enable && (r_psc >= i_prescaler);
        // A zero period in center mode degenerates to edge counting.
        w_center   = (i_mode == PWM_CENTER) && (i_period != '0);
        w_psc_nxt  = r_psc + c_psc_one;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_boundary = 1'b0;
        if (!i_enable) begin
            w_psc_nxt = '0;
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_tick) begin
            w_psc_nxt = '0;
            if (!w_center) begin
                w_dir_nxt = DIR_UP;
                if (r_cnt >= i_period) begin
                    w_cnt_nxt  = '0;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end else if (r_dir == DIR_UP) begin
                // Direction flips on the tick that reaches the top count.
                if (r_cnt >= i_period - c_cnt_one) begin
                    w_cnt_nxt = i_period;
                    w_dir_nxt = DIR_DOWN;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end else begin
                if (r_cnt <= c_cnt_one) begin
                    w_cnt_nxt  = '0;
                    w_dir_nxt  = DIR_UP;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multichannel
//  Description : N-channel PWM with shared timebase and shadow configuration
//                committed at period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_multichannel_if.slave bus
);

    pwm_mode_e               r_act_mode;
    logic [CNT_W-1:0]        r_act_period;
    logic [PSC_W-1:0]        r_act_psc;
    logic [NUM_CH*CNT_W-1:0] r_act_duty;
    logic [NUM_CH-1:0]       r_act_pol;

    pwm_mode_e               r_pnd_mode;
    logic [CNT_W-1:0]        r_pnd_period;
    logic [PSC_W-1:0]        r_pnd_psc;
    logic [NUM_CH*CNT_W-1:0] r_pnd_duty;
    logic [NUM_CH-1:0]       r_pnd_pol;
    logic                    r_pending;

    logic [NUM_CH-1:0]       r_pwm;
    logic                    r_period_tick;

    logic [CNT_W-1:0]        w_cnt;
    logic                    w_boundary;
    logic                    w_commit;
    logic [NUM_CH-1:0]       w_raw;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (bus.enable),
        .i_mode      (r_act_mode),
        .i_period    (r_act_period),
        .i_prescaler (r_act_psc),
        .o_cnt       (w_cnt),
        .o_boundary  (w_boundary)
    );

    // While idle there is no period to wait for, so pending config goes live at once.
    assign w_commit = r_pending && (w_boundary || !bus.enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_mode   <= PWM_EDGE;
            r_act_period <= '0;
            r_act_psc    <= '0;
            r_act_duty   <= '0;
            r_act_pol    <= '0;
            r_pnd_mode   <= PWM_EDGE;
            r_pnd_period <= '0;
            r_pnd_psc    <= '0;
            r_pnd_duty   <= '0;
            r_pnd_pol    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_commit) begin
                r_act_mode   <= r_pnd_mode;
                r_act_period <= r_pnd_period;
                r_act_psc    <= r_pnd_psc;
                r_act_duty   <= r_pnd_duty;
                r_act_pol    <= r_pnd_pol;
            end
            if (bus.cfg_load) begin
                r_pnd_mode   <= pwm_mode_e'(bus.center_mode);
                r_pnd_period <= bus.period;
                r_pnd_psc    <= bus.prescaler;
                r_pnd_duty   <= bus.duty;
                r_pnd_pol    <= bus.polarity;
                r_pending    <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_raw[gi] = (w_cnt < r_act_duty[gi*CNT_W +: CNT_W]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm         <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_pwm         <= bus.enable ? (w_raw ^ r_act_pol) : r_act_pol;
            r_period_tick <= w_boundary;
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.period_tick = r_period_tick;
    assign bus.cfg_pending = r_pending;

endmodule
`default_nettype wire

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator, the next generation of the chip's fixed 3-channel/32-bit PWM. It provides N channels that share a prescaled timebase, with edge- or center-aligned counting, per-channel output polarity, and double-buffered (shadow) configuration that commits glitch-free at period boundaries. It sits between the SPI register file, which drives the config inputs, and the `uo_out` pins.

## Interface

- `NUM_CH`, default 4: number of PWM channels (1–8)
- `CNT_W`, default 16: width of the period, counter and duty values
- `PSC_W`, default 16: prescaler width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  run timebase; low = hold at idle
- `cfg_load`  in  1  one-cycle pulse; captures all config inputs below into the pending set
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned
- `period`  in  CNT_W  top count P
- `prescaler`  in  PSC_W  tick every prescaler+1 clocks
- `duty`  in  NUM_CH*CNT_W  channel i is at bits [i*CNT_W +: CNT_W]
- `polarity`  in  NUM_CH  1 = invert channel output
- `pwm_out`  out  NUM_CH  registered PWM outputs
- `period_tick`  out  1  one-cycle pulse at each period boundary
- `cfg_pending`  out  1  pending config not yet committed

## Operation

- **Config sets:**
  - Pending set: loaded by `cfg_load`.
  - Active set: used by the logic.
  - Inputs are ignored except on `cfg_load`.
- **Prescaler:**
  - `psc_cnt` counts 0..active prescaler.
  - `tick` fires when `psc_cnt == prescaler`, then `psc_cnt` returns to 0.
  - prescaler = 0 gives a tick every clk.
- **Counter, edge mode:** `cnt` counts 0..P, then wraps to 0. Period is P+1 ticks.
- **Counter, center mode:**
  - States UP and DOWN. UP: cnt++ until P, then DOWN. DOWN: cnt-- until 0, then UP.
  - Period is 2P ticks.
  - With P = 0, center mode behaves as edge mode.
- **Boundary:** the tick on which the next `cnt` is 0 at the start of a new period (edge: P→0; center: 1→0 in DOWN). With P = 0 in edge mode, every tick is a boundary.
- **Channel compare:**
  - `raw_i = (cnt < duty_i)`.
  - duty = 0 gives constantly 0; duty > P gives constantly 1.
  - `pwm_out[i] <= raw_i ^ polarity_i`.
- **Commit:**
  - On a boundary with `cfg_pending = 1`, the active set takes the pending set and `cfg_pending` clears. The new values take effect from the first count of the new period.
  - If `enable = 0`, the commit happens on the cycle after `cfg_load`.
- **Repeated loads:** `cfg_load` while pending overwrites the pending set, and `cfg_pending` stays 1.
- **cfg_load coinciding with a boundary:** the boundary commits the old pending set, the new values are captured as pending, and `cfg_pending` stays 1.
- **enable low:**
  - `psc_cnt`, `cnt` = 0; direction = UP.
  - `pwm_out = polarity` (idle level); `period_tick = 0`.
- **enable rising:** counting starts from `cnt = 0`. The first boundary occurs after a full period.
- **Reset:**
  - Active and pending sets are all 0 (P = 0, prescaler = 0, duty = 0, polarity = 0, edge mode).
  - `pwm_out = 0`, `period_tick = 0`, `cfg_pending = 0`, `cnt = 0`, direction = UP.
- **Width rules:**
  - Compares are unsigned, at CNT_W.
  - No arithmetic overflow is possible: `cnt` never exceeds P.
  - The all-ones duty value is constantly 1 unless P is also all-ones.

## Timing

- `pwm_out` lags the `cnt` compare by 1 clk.
- `period_tick` is asserted in the same cycle that `cnt` becomes 0 for the new period.
- Commit latency from `cfg_load`:
  - enabled: up to one full period plus 1 clk;
  - disabled: 1 clk.
- `cfg_pending` rises the cycle after `cfg_load` and falls the cycle after the commit boundary.
- Asserting `rst_n` low mid-period forces all outputs to their reset values immediately (asynchronous). There is no partial period on release.

## Structure

- Package `pwm_pkg`:
  - `pwm_mode_e` (PWM_EDGE, PWM_CENTER);
  - `pwm_dir_e` (DIR_UP, DIR_DOWN);
  - max-channel constant.
- Sub-module `pwm_timebase`: prescaler, counter, direction FSM, `tick`/boundary generation.
- Top level: shadow/active registers, commit logic, and a generate loop of per-channel comparators.

## Test plan

1. **Edge mode, no prescale:** P = 9, prescaler = 0, duty = {0, 3, 10, 15}, polarity = 0 → ch0 constantly 0; ch1 high 3 of every 10 clk; ch2 and ch3 constantly 1; `period_tick` every 10 clk.
2. **Prescaler:** prescaler = 2, P = 4, duty = 2, edge mode → high 6 clk, low 9 clk; period 15 clk.
3. **Center mode:** P = 4, duty = 2 → `cnt` sequence 0,1,2,3,4,3,2,1; output high on the contiguous run 1,0,1 (3 of 8 ticks, symmetric about 0); `period_tick` every 8 ticks.
4. **Shadow update:** `cfg_load` of duty 7 at mid-period while duty is 3 → old duty kept until the boundary; `cfg_pending` = 1 until then; next period high 7 of 10. A second `cfg_load` on the boundary cycle leaves `cfg_pending` = 1.
5. **Disabled / polarity:** `enable` = 0, polarity = 1 → `pwm_out` all 1; `cfg_load` commits after 1 clk; on `enable` rising, the first `period_tick` comes after a full period.
6. **Reset mid-run:** `rst_n` low while outputs are high → `pwm_out`, `cfg_pending`, `period_tick` = 0 immediately. After release with `enable` = 1 and no load: outputs stay 0 and `period_tick` fires every clk (P = 0).
